// File: rtl/jas_move_queue.sv
// Queues motion-profile parameter sets and sequences them into the step generator: load, dir setup, start/finish handshake, release.
// Load one cycle after push when idle; start rises DIR_SETUP cycles after load; cmd_ready drops when full or aborting, so commands are held, never lost.
module jas_move_queue #(
  parameter int DEPTH     = 8,
  parameter int DIR_SETUP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     abort,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [0:4][31:0]         cmd_params,
  input  logic                     cmd_dir,
  output logic [0:4][31:0]         params,
  output logic                     dir,
  output logic                     start,
  input  logic                     finish,
  output logic                     busy,
  output logic                     move_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              moves_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(DIR_SETUP + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   setup_cnt, setup_cnt_nxt;
  logic            start_nxt;
  logic            done_nxt;
  logic            moves_inc;
  logic            pop;
  logic            push;
  logic            full;
  logic            empty;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [0:4][31:0] mem_params [DEPTH];
  logic             mem_dir    [DEPTH];

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt     = state;
    setup_cnt_nxt = setup_cnt;
    start_nxt     = start;
    done_nxt      = 1'b0;
    moves_inc     = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          pop           = 1'b1;
          setup_cnt_nxt = '0;
          state_nxt     = SETUP;
        end
      end
      SETUP: begin
        start_nxt = 1'b0;
        if (setup_cnt == SW'(DIR_SETUP - 1)) begin
          start_nxt = 1'b1;
          state_nxt = RUN;
        end else begin
          setup_cnt_nxt = setup_cnt + 1'b1;
        end
      end
      RUN: begin
        if (finish) begin
          start_nxt = 1'b0;
          done_nxt  = 1'b1;
          moves_inc = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        start_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything: the in-flight move is dropped without completion credit
    if (abort) begin
      state_nxt = IDLE;
      start_nxt = 1'b0;
      done_nxt  = 1'b0;
      moves_inc = 1'b0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      setup_cnt  <= '0;
      start      <= 1'b0;
      move_done  <= 1'b0;
      busy       <= 1'b0;
      moves_done <= '0;
      params     <= '0;
      dir        <= 1'b0;
    end else begin
      state     <= state_nxt;
      setup_cnt <= setup_cnt_nxt;
      start     <= start_nxt;
      move_done <= done_nxt;
      busy      <= (state_nxt != IDLE);
      if (moves_inc) moves_done <= moves_done + 16'd1;
      if (pop) begin
        params <= mem_params[rd_ptr];
        dir    <= mem_dir[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written
  always_ff @(posedge clk) begin
    if (push) begin
      mem_params[wr_ptr] <= cmd_params;
      mem_dir[wr_ptr]    <= cmd_dir;
    end
  end

endmodule
